avalon_mem_test_slave: RTL and testbench
========================================

AVALON_MEM_TEST_SLAVE -- requirements
Module: avalon_mem_test_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 30, word-address width.
REQ-003 SHALL have parameter NUM_PERIPH_SEL_BITS, default 5, number of upper address bits used for peripheral select.
REQ-004 SHALL have parameter PERIPH_SEL, default 0, select value matched against those upper bits.
REQ-005 SHALL have parameter DEPTH_LOG2, default 8, log2 of memory depth in words.
REQ-006 SHALL have parameter WRITE_WAIT_CYCLES, default 0, waitrequest cycles inserted per write.
REQ-007 SHALL have parameter READ_WAIT_CYCLES, default 0, waitrequest cycles inserted per read.
REQ-008 SHALL have parameter READ_LATENCY, default 0, 0 = fixed read data in the accept cycle, 1..8 = pipelined read with readdatavalid.
REQ-009 SHALL have one clock and an asynchronous active-low reset; ports are listed below.
REQ-010 i_Clk  in  1  clock, all state on rising edge.
REQ-011 i_Rst_n  in  1  asynchronous active-low reset.
REQ-012 i_AV_Addr  in  ADDR_W  word address.
REQ-013 i_AV_ByteEn  in  DATA_W/8  byte enables.
REQ-014 i_AV_Read  in  1  read request.
REQ-015 i_AV_Write  in  1  write request.
REQ-016 i_AV_WriteData  in  DATA_W  write data.
REQ-017 o_AV_ReadData  out  DATA_W  read data.
REQ-018 o_AV_ReadDataValid  out  1  read data valid (READ_LATENCY>0 only; tied 0 otherwise).
REQ-019 o_AV_WaitRequest  out  1  stall; master holds request and signals while high.
REQ-020 o_Err  out  1  sticky protocol-error flag.
REQ-021 o_WrCount, o_RdCount  out  16 each  saturating counts of completed writes and reads.

Function
REQ-022 Selected = i_AV_Addr[ADDR_W-1 -: NUM_PERIPH_SEL_BITS] == PERIPH_SEL; memory word index = i_AV_Addr[DEPTH_LOG2-1:0].
REQ-023 Unselected requests: no state change, o_AV_WaitRequest=0, no counter increment.
REQ-024 FSM states: IDLE, WAIT_WR, WAIT_RD; wait counter width sufficient for max(WRITE_WAIT_CYCLES, READ_WAIT_CYCLES).
REQ-025 IDLE + selected write: if WRITE_WAIT_CYCLES=0, commit in the same edge with waitrequest 0; else assert waitrequest combinationally, go WAIT_WR.
REQ-026 IDLE + selected read: behaves the same way with READ_WAIT_CYCLES, going to WAIT_RD.
REQ-027 In a WAIT state, waitrequest stays high until the counter reaches N; on the cycle it is low the transfer completes and the FSM returns to IDLE.
REQ-028 A request with N waits is therefore accepted in cycle N+1 (counting the first request cycle as 1).
REQ-029 Write commit updates only bytes with ByteEn=1.
REQ-030 Back-to-back requests are allowed: a new request in the cycle after acceptance starts a fresh sequence.
REQ-031 READ_LATENCY=0: o_AV_ReadData = mem[index] combinationally during the accept cycle.
REQ-032 READ_LATENCY=L>0: read data is captured at the accept edge and presented with o_AV_ReadDataValid=1 exactly L cycles after the accept cycle.
REQ-033 With READ_LATENCY>0, up to L reads may be outstanding and returned in order, one per cycle.
REQ-034 Read and write of the same word in consecutive accepts: the read returns the newly written data.
REQ-035 Read and write both high while selected: set o_Err, perform no transfer, waitrequest 0, stay/return IDLE.
REQ-036 Request dropped while in a WAIT state: set o_Err, abort with no transfer, return IDLE.
REQ-037 Counters saturate at 16'hFFFF and do not wrap.
REQ-038 o_AV_ReadData SHALL hold its last value when not valid.

Reset
REQ-039 Reset SHALL be asynchronous on i_Rst_n low; on deassertion all state SHALL resume synchronously.
REQ-040 Reset values: FSM IDLE, wait counter 0, o_AV_WaitRequest 0, o_AV_ReadDataValid 0, read pipeline valids 0, o_AV_ReadData 0, o_Err 0, counters 0.
REQ-041 Memory contents are not reset (undefined until written).
REQ-042 Reset mid-wait or mid-pipeline discards the transfer and any in-flight read data.

Structure
REQ-043 Package avalon_pkg SHALL hold the FSM state typedef and the default DATA_W/ADDR_W constants.
REQ-044 Sub-module avalon_rd_pipe (parametrised DATA_W, READ_LATENCY) SHALL implement the read data/valid delay line.

Verification
REQ-045 Defaults: write 0x5A5A5A5A to addr 0, then read addr 0 -> waitrequest never high; ReadData=0x5A5A5A5A in the read cycle; WrCount=1, RdCount=1.
REQ-046 WRITE_WAIT_CYCLES=3, READ_WAIT_CYCLES=2: write addr 4 -> waitrequest high for exactly 3 cycles; read -> high for 2 cycles with correct data.
REQ-047 ByteEn=4'b0101, data 0xFFFFFFFF onto a word holding 0x12345678 -> reads 0x12FF56FF.
REQ-048 READ_LATENCY=3: four back-to-back reads of addrs 0..3 -> ReadDataValid high for 4 consecutive cycles starting 3 cycles after the first accept, data in order.
REQ-049 Read+Write asserted together, and a read dropped mid-wait -> o_Err=1, memory unchanged, counters unchanged.
REQ-050 Address with upper bits != PERIPH_SEL -> no waitrequest, no write, counters unchanged; reset asserted mid-wait -> WaitRequest=0 immediately.

Source files
------------

// File: rtl/avalon_pkg.sv
// rtl/avalon_pkg.sv - shared types and default widths for the Avalon memory test slave
package avalon_pkg;

  localparam int AV_DATA_W = 32;
  localparam int AV_ADDR_W = 30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_WR = 2'd1,
    ST_WAIT_RD = 2'd2
  } av_state_t;

endpackage

// File: rtl/avalon_rd_pipe.sv
// rtl/avalon_rd_pipe.sv - read data/valid delay line for pipelined read latency
module avalon_rd_pipe #(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Valid,
  input  logic [DATA_W-1:0] i_Data,
  output logic              o_Valid,
  output logic [DATA_W-1:0] o_Data
);

  logic [READ_LATENCY-1:0] vld;
  logic [DATA_W-1:0]       dat [READ_LATENCY];

  // Shift valids every cycle; a data stage only loads when the stage before it
  // is valid, so the last stage keeps presenting the most recent returned word.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= i_Valid;
      if (i_Valid) dat[0] <= i_Data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign o_Valid = vld[READ_LATENCY-1];
  assign o_Data  = dat[READ_LATENCY-1];

endmodule

// File: rtl/avalon_mem_test_slave.sv
// rtl/avalon_mem_test_slave.sv - Avalon-MM memory slave with programmable waits and read latency
module avalon_mem_test_slave
  import avalon_pkg::*;
#(
  parameter int DATA_W              = AV_DATA_W,
  parameter int ADDR_W              = AV_ADDR_W,
  parameter int NUM_PERIPH_SEL_BITS = 5,
  parameter int PERIPH_SEL          = 0,
  parameter int DEPTH_LOG2          = 8,
  parameter int WRITE_WAIT_CYCLES   = 0,
  parameter int READ_WAIT_CYCLES    = 0,
  parameter int READ_LATENCY        = 0
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic [ADDR_W-1:0]   i_AV_Addr,
  input  logic [DATA_W/8-1:0] i_AV_ByteEn,
  input  logic                i_AV_Read,
  input  logic                i_AV_Write,
  input  logic [DATA_W-1:0]   i_AV_WriteData,
  output logic [DATA_W-1:0]   o_AV_ReadData,
  output logic                o_AV_ReadDataValid,
  output logic                o_AV_WaitRequest,
  output logic                o_Err,
  output logic [15:0]         o_WrCount,
  output logic [15:0]         o_RdCount
);

  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam int BE_W     = DATA_W / 8;
  localparam int MAX_WAIT = (WRITE_WAIT_CYCLES > READ_WAIT_CYCLES) ? WRITE_WAIT_CYCLES : READ_WAIT_CYCLES;
  localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  av_state_t             state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  sel;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  wr_acc, rd_acc, err_set, wait_req;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic                  unused_addr_bits;

  assign sel = (i_AV_Addr[ADDR_W-1 -: NUM_PERIPH_SEL_BITS] == NUM_PERIPH_SEL_BITS'(PERIPH_SEL));
  assign idx = i_AV_Addr[DEPTH_LOG2-1:0];
  assign unused_addr_bits = &{1'b0, i_AV_Addr};

  // State and wait-counter register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state, waitrequest and transfer strobes; the counter starts at 1 because
  // the first request cycle is already the first wait cycle.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    wait_req = 1'b0;
    wr_acc   = 1'b0;
    rd_acc   = 1'b0;
    err_set  = 1'b0;
    if (i_Rst_n) begin
      case (state)
        ST_IDLE: begin
          if (sel && i_AV_Read && i_AV_Write) begin
            err_set = 1'b1;
          end else if (sel && i_AV_Write) begin
            if (WRITE_WAIT_CYCLES == 0) begin
              wr_acc = 1'b1;
            end else begin
              wait_req = 1'b1;
              state_n  = ST_WAIT_WR;
              cnt_n    = CNT_W'(1);
            end
          end else if (sel && i_AV_Read) begin
            if (READ_WAIT_CYCLES == 0) begin
              rd_acc = 1'b1;
            end else begin
              wait_req = 1'b1;
              state_n  = ST_WAIT_RD;
              cnt_n    = CNT_W'(1);
            end
          end
        end
        ST_WAIT_WR: begin
          if (!sel || !i_AV_Write || i_AV_Read) begin
            err_set = 1'b1;
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else if (cnt == CNT_W'(WRITE_WAIT_CYCLES)) begin
            wr_acc  = 1'b1;
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            wait_req = 1'b1;
            cnt_n    = cnt + CNT_W'(1);
          end
        end
        ST_WAIT_RD: begin
          if (!sel || !i_AV_Read || i_AV_Write) begin
            err_set = 1'b1;
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else if (cnt == CNT_W'(READ_WAIT_CYCLES)) begin
            rd_acc  = 1'b1;
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            wait_req = 1'b1;
            cnt_n    = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign o_AV_WaitRequest = wait_req;

  // Byte-masked write into the (unreset) memory array.
  always_ff @(posedge i_Clk) begin
    if (wr_acc) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_AV_ByteEn[b]) mem[idx][b*8 +: 8] <= i_AV_WriteData[b*8 +: 8];
      end
    end
  end

  // Sticky error flag and saturating transfer counters.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Err     <= 1'b0;
      o_WrCount <= '0;
      o_RdCount <= '0;
    end else begin
      if (err_set) o_Err <= 1'b1;
      if (wr_acc && o_WrCount != 16'hFFFF) o_WrCount <= o_WrCount + 16'd1;
      if (rd_acc && o_RdCount != 16'hFFFF) o_RdCount <= o_RdCount + 16'd1;
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_rd
      logic [DATA_W-1:0] rd_hold;

      // Remember the last word returned so the bus holds it between reads.
      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) rd_hold <= '0;
        else if (rd_acc) rd_hold <= mem[idx];
      end

      assign o_AV_ReadData      = rd_acc ? mem[idx] : rd_hold;
      assign o_AV_ReadDataValid = 1'b0;
    end else begin : g_pipe_rd
      avalon_rd_pipe #(
        .DATA_W      (DATA_W),
        .READ_LATENCY(READ_LATENCY)
      ) u_rd_pipe (
        .i_Clk  (i_Clk),
        .i_Rst_n(i_Rst_n),
        .i_Valid(rd_acc),
        .i_Data (mem[idx]),
        .o_Valid(o_AV_ReadDataValid),
        .o_Data (o_AV_ReadData)
      );
    end
  endgenerate

endmodule

// File: tb/tb_avalon_mem_test_slave.sv
// tb/tb_avalon_mem_test_slave.sv - self-checking bench for avalon_mem_test_slave
module tb_avalon_mem_test_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: 3/2 wait cycles, select 1. Instance 2: latency 3, select 3.
  logic [2:0]        rst_n;
  logic [2:0][29:0]  av_addr;
  logic [2:0][3:0]   av_be;
  logic [2:0]        av_rd, av_wr;
  logic [2:0][31:0]  av_wd, av_rdata;
  logic [2:0]        rdv, wreq, err;
  logic [2:0][15:0]  wrc, rdc;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  avalon_mem_test_slave u_a (
    .i_Clk(clk), .i_Rst_n(rst_n[0]), .i_AV_Addr(av_addr[0]), .i_AV_ByteEn(av_be[0]),
    .i_AV_Read(av_rd[0]), .i_AV_Write(av_wr[0]), .i_AV_WriteData(av_wd[0]),
    .o_AV_ReadData(av_rdata[0]), .o_AV_ReadDataValid(rdv[0]), .o_AV_WaitRequest(wreq[0]),
    .o_Err(err[0]), .o_WrCount(wrc[0]), .o_RdCount(rdc[0]));

  avalon_mem_test_slave #(.PERIPH_SEL(1), .WRITE_WAIT_CYCLES(3), .READ_WAIT_CYCLES(2)) u_b (
    .i_Clk(clk), .i_Rst_n(rst_n[1]), .i_AV_Addr(av_addr[1]), .i_AV_ByteEn(av_be[1]),
    .i_AV_Read(av_rd[1]), .i_AV_Write(av_wr[1]), .i_AV_WriteData(av_wd[1]),
    .o_AV_ReadData(av_rdata[1]), .o_AV_ReadDataValid(rdv[1]), .o_AV_WaitRequest(wreq[1]),
    .o_Err(err[1]), .o_WrCount(wrc[1]), .o_RdCount(rdc[1]));

  avalon_mem_test_slave #(.PERIPH_SEL(3), .READ_LATENCY(3)) u_c (
    .i_Clk(clk), .i_Rst_n(rst_n[2]), .i_AV_Addr(av_addr[2]), .i_AV_ByteEn(av_be[2]),
    .i_AV_Read(av_rd[2]), .i_AV_Write(av_wr[2]), .i_AV_WriteData(av_wd[2]),
    .o_AV_ReadData(av_rdata[2]), .o_AV_ReadDataValid(rdv[2]), .o_AV_WaitRequest(wreq[2]),
    .o_Err(err[2]), .o_WrCount(wrc[2]), .o_RdCount(rdc[2]));

  // Reference model: word arrays, expected counts, expected pipelined returns.
  logic [31:0] ref_mem [3][256];
  int          ref_wr [3];
  int          ref_rd [3];
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] got_q[$];
  int          got_cyc_q[$];
  bit          stray_rdv = 1'b0;

  always @(negedge clk) begin
    if (rst_n[2] === 1'b1 && rdv[2] === 1'b1) begin
      got_q.push_back(av_rdata[2]);
      got_cyc_q.push_back(cyc);
    end
    if (rdv[0] !== 1'b0 || rdv[1] !== 1'b0) stray_rdv = 1'b1;
  end

  function automatic int ww(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  function automatic int rw(input int k);
    return (k == 1) ? 2 : 0;
  endfunction

  function automatic int psel(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic logic [29:0] sel_addr(input int k, input int idx);
    logic [4:0] p;
    p = 5'(psel(k));
    return {p, 25'(idx)};
  endfunction

  task automatic do_xfer(input int k, input bit is_wr, input bit is_rd, input logic [29:0] a,
                         input logic [3:0] be, input logic [31:0] d,
                         output int waits, output logic [31:0] rd_now, output int acc_cyc);
    @(negedge clk);
    av_addr[k] = a; av_be[k] = be; av_wd[k] = d; av_wr[k] = is_wr; av_rd[k] = is_rd;
    waits = 0;
    #1;
    while (wreq[k] !== 1'b0 && waits < 20) begin
      waits++;
      @(negedge clk);
      #1;
    end
    rd_now  = av_rdata[k];
    acc_cyc = cyc;
    if (waits >= 20) begin
      tests++; fails++;
      $display("FAIL xfer_timeout inst=%0d waitrequest still %b after %0d cycles, required 0", k, wreq[k], waits);
    end
    @(posedge clk);
  endtask

  task automatic bus_idle(input int k);
    @(negedge clk);
    av_rd[k] = 1'b0; av_wr[k] = 1'b0;
  endtask

  task automatic do_wr(input int k, input int idx, input logic [3:0] be, input logic [31:0] d, output int waits);
    logic [31:0] dummy;
    int acc;
    do_xfer(k, 1'b1, 1'b0, sel_addr(k, idx), be, d, waits, dummy, acc);
    for (int b = 0; b < 4; b++) if (be[b]) ref_mem[k][idx][b*8 +: 8] = d[b*8 +: 8];
    ref_wr[k]++;
  endtask

  task automatic do_rd(input int k, input int idx, output int waits, output logic [31:0] rd_now);
    int acc;
    do_xfer(k, 1'b0, 1'b1, sel_addr(k, idx), 4'hF, 32'h0, waits, rd_now, acc);
    ref_rd[k]++;
    if (k == 2) begin
      exp_q.push_back(ref_mem[k][idx]);
      exp_cyc_q.push_back(acc + 3);
    end
  endtask

  task automatic test_reset;
    rst_n = 3'b000; av_rd = '0; av_wr = '0; av_addr = '0; av_be = '0; av_wd = '0;
    repeat (3) @(negedge clk);
    rst_n = 3'b111;
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      ref_wr[k] = 0; ref_rd[k] = 0;
      tests++; if (wreq[k] !== 1'b0) begin fails++; $display("FAIL reset_waitreq inst=%0d got %b want 0", k, wreq[k]); end
      tests++; if (rdv[k] !== 1'b0) begin fails++; $display("FAIL reset_rdvalid inst=%0d got %b want 0", k, rdv[k]); end
      tests++; if (av_rdata[k] !== 32'h0) begin fails++; $display("FAIL reset_rdata inst=%0d got %h want 0", k, av_rdata[k]); end
      tests++; if (err[k] !== 1'b0) begin fails++; $display("FAIL reset_err inst=%0d got %b want 0", k, err[k]); end
      tests++; if (wrc[k] !== 16'd0 || rdc[k] !== 16'd0) begin fails++; $display("FAIL reset_counts inst=%0d got wr=%0d rd=%0d want 0/0", k, wrc[k], rdc[k]); end
    end
  endtask

  task automatic test_basic;
    int w1, w2;
    logic [31:0] r;
    do_wr(0, 0, 4'hF, 32'h5A5A5A5A, w1);
    do_rd(0, 0, w2, r);
    bus_idle(0);
    #1;
    tests++; if (w1 != 0 || w2 != 0) begin fails++; $display("FAIL basic_waits got wr=%0d rd=%0d want 0/0", w1, w2); end
    tests++; if (r !== 32'h5A5A5A5A) begin fails++; $display("FAIL basic_rdata got %h want 5a5a5a5a", r); end
    tests++; if (wrc[0] !== 16'd1 || rdc[0] !== 16'd1) begin fails++; $display("FAIL basic_counts got wr=%0d rd=%0d want 1/1", wrc[0], rdc[0]); end
  endtask

  task automatic test_waits;
    int w1, w2;
    logic [31:0] r, d;
    d = $urandom;
    do_wr(1, 4, 4'hF, d, w1);
    do_rd(1, 4, w2, r);
    bus_idle(1);
    #1;
    tests++; if (w1 != 3) begin fails++; $display("FAIL wait_wr_cycles got %0d want 3", w1); end
    tests++; if (w2 != 2) begin fails++; $display("FAIL wait_rd_cycles got %0d want 2", w2); end
    tests++; if (r !== d) begin fails++; $display("FAIL wait_rdata got %h want %h", r, d); end
    tests++; if (wrc[1] !== 16'(ref_wr[1]) || rdc[1] !== 16'(ref_rd[1])) begin fails++; $display("FAIL wait_counts got wr=%0d rd=%0d want %0d/%0d", wrc[1], rdc[1], ref_wr[1], ref_rd[1]); end
  endtask

  task automatic test_byteen;
    int w;
    logic [31:0] r;
    for (int k = 0; k < 2; k++) begin
      do_wr(k, 8, 4'hF, 32'h12345678, w);
      do_wr(k, 8, 4'b0101, 32'hFFFFFFFF, w);
      do_rd(k, 8, w, r);
      bus_idle(k);
      tests++; if (r !== 32'h12FF56FF) begin fails++; $display("FAIL byteen inst=%0d got %h want 12ff56ff", k, r); end
    end
  endtask

  task automatic test_back_to_back;
    int w;
    logic [31:0] r, d;
    for (int k = 0; k < 2; k++) begin
      d = $urandom;
      do_wr(k, 5, 4'hF, d, w);
      do_rd(k, 5, w, r);
      bus_idle(k);
      tests++; if (r !== d) begin fails++; $display("FAIL b2b_wr_then_rd inst=%0d got %h want %h", k, r, d); end
    end
  endtask

  task automatic test_pipeline;
    int w;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) do_wr(2, i, 4'hF, $urandom, w);
    bus_idle(2);
    for (int i = 0; i < 4; i++) do_rd(2, i, w, r);
    bus_idle(2);
    repeat (6) @(negedge clk);
    tests++; if (got_q.size() != 4) begin fails++; $display("FAIL pipe_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i] || got_cyc_q[i] != exp_cyc_q[i] || got_cyc_q[i] != got_cyc_q[0] + i) begin
        fails++; $display("FAIL pipe_beat%0d got %h@%0d want %h@%0d", i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
      end
    end
    exp_q.delete(); exp_cyc_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_random;
    int w, idx, op;
    logic [31:0] r, d;
    logic [3:0] be;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) do_wr(k, i, 4'hF, $urandom, w);
      for (int n = 0; n < 30; n++) begin
        idx = $urandom_range(0, 15);
        op  = $urandom_range(0, 2);
        if (op == 0) begin
          be = 4'($urandom); d = $urandom;
          do_wr(k, idx, be, d, w);
          tests++; if (w != ww(k)) begin fails++; $display("FAIL rand_wr_waits inst=%0d got %0d want %0d", k, w, ww(k)); end
        end else begin
          do_rd(k, idx, w, r);
          tests++; if (w != rw(k)) begin fails++; $display("FAIL rand_rd_waits inst=%0d got %0d want %0d", k, w, rw(k)); end
          if (k < 2) begin
            tests++; if (r !== ref_mem[k][idx]) begin fails++; $display("FAIL rand_rdata inst=%0d idx=%0d got %h want %h", k, idx, r, ref_mem[k][idx]); end
          end
        end
        if ($urandom_range(0, 2) == 0) bus_idle(k);
      end
      bus_idle(k);
      repeat (6) @(negedge clk);
      #1;
      tests++; if (wrc[k] !== 16'(ref_wr[k]) || rdc[k] !== 16'(ref_rd[k])) begin fails++; $display("FAIL rand_counts inst=%0d got wr=%0d rd=%0d want %0d/%0d", k, wrc[k], rdc[k], ref_wr[k], ref_rd[k]); end
    end
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_pipe_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i] || got_cyc_q[i] != exp_cyc_q[i]) begin
        fails++; $display("FAIL rand_pipe_beat%0d got %h@%0d want %h@%0d", i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
      end
    end
    exp_q.delete(); exp_cyc_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_error;
    int w, acc;
    logic [31:0] r;
    tests++; if (err[0] !== 1'b0) begin fails++; $display("FAIL err_pre_a got %b want 0", err[0]); end
    do_xfer(0, 1'b1, 1'b1, sel_addr(0, 2), 4'hF, ~ref_mem[0][2], w, r, acc);
    bus_idle(0);
    #1;
    tests++; if (w != 0) begin fails++; $display("FAIL err_rdwr_waits got %0d want 0", w); end
    tests++; if (err[0] !== 1'b1) begin fails++; $display("FAIL err_rdwr_flag got %b want 1", err[0]); end
    tests++; if (wrc[0] !== 16'(ref_wr[0]) || rdc[0] !== 16'(ref_rd[0])) begin fails++; $display("FAIL err_rdwr_counts got wr=%0d rd=%0d want %0d/%0d", wrc[0], rdc[0], ref_wr[0], ref_rd[0]); end
    do_rd(0, 2, w, r);
    bus_idle(0);
    tests++; if (r !== ref_mem[0][2]) begin fails++; $display("FAIL err_rdwr_mem got %h want %h", r, ref_mem[0][2]); end

    tests++; if (err[1] !== 1'b0) begin fails++; $display("FAIL err_pre_b got %b want 0", err[1]); end
    @(negedge clk);
    av_addr[1] = sel_addr(1, 3); av_rd[1] = 1'b1; av_wr[1] = 1'b0;
    #1;
    tests++; if (wreq[1] !== 1'b1) begin fails++; $display("FAIL err_drop_wait_first got %b want 1", wreq[1]); end
    @(negedge clk);
    av_rd[1] = 1'b0;
    #1;
    tests++; if (wreq[1] !== 1'b0) begin fails++; $display("FAIL err_drop_wait_after got %b want 0", wreq[1]); end
    @(negedge clk);
    #1;
    tests++; if (err[1] !== 1'b1) begin fails++; $display("FAIL err_drop_flag got %b want 1", err[1]); end
    tests++; if (rdc[1] !== 16'(ref_rd[1]) || wrc[1] !== 16'(ref_wr[1])) begin fails++; $display("FAIL err_drop_counts got wr=%0d rd=%0d want %0d/%0d", wrc[1], rdc[1], ref_wr[1], ref_rd[1]); end
  endtask

  task automatic test_unselected;
    int w, acc;
    logic [31:0] r;
    logic [29:0] a;
    a = sel_addr(0, 3);
    a[29:25] = 5'd7;
    do_xfer(0, 1'b1, 1'b0, a, 4'hF, ~ref_mem[0][3], w, r, acc);
    bus_idle(0);
    #1;
    tests++; if (w != 0) begin fails++; $display("FAIL unsel_waits got %0d want 0", w); end
    tests++; if (wrc[0] !== 16'(ref_wr[0])) begin fails++; $display("FAIL unsel_wrcount got %0d want %0d", wrc[0], ref_wr[0]); end
    do_rd(0, 3, w, r);
    bus_idle(0);
    tests++; if (r !== ref_mem[0][3]) begin fails++; $display("FAIL unsel_mem got %h want %h", r, ref_mem[0][3]); end
  endtask

  task automatic test_reset_midwait;
    int w;
    logic [31:0] r;
    @(negedge clk);
    av_addr[1] = sel_addr(1, 6); av_be[1] = 4'hF; av_wd[1] = ~ref_mem[1][6]; av_wr[1] = 1'b1;
    @(negedge clk);
    #1;
    tests++; if (wreq[1] !== 1'b1) begin fails++; $display("FAIL rst_mid_wait_pre got %b want 1", wreq[1]); end
    rst_n[1] = 1'b0;
    #1;
    tests++; if (wreq[1] !== 1'b0) begin fails++; $display("FAIL rst_mid_wait_now got %b want 0", wreq[1]); end
    tests++; if (err[1] !== 1'b0 || wrc[1] !== 16'd0 || rdc[1] !== 16'd0) begin fails++; $display("FAIL rst_mid_state got err=%b wr=%0d rd=%0d want 0/0/0", err[1], wrc[1], rdc[1]); end
    @(negedge clk);
    av_wr[1] = 1'b0;
    rst_n[1] = 1'b1;
    ref_wr[1] = 0; ref_rd[1] = 0;
    do_rd(1, 6, w, r);
    bus_idle(1);
    tests++; if (r !== ref_mem[1][6]) begin fails++; $display("FAIL rst_mid_wr_discard got %h want %h", r, ref_mem[1][6]); end

    do_rd(2, 1, w, r);
    #2;
    rst_n[2] = 1'b0;
    av_rd[2] = 1'b0;
    exp_q.delete(); exp_cyc_q.delete();
    @(negedge clk);
    rst_n[2] = 1'b1;
    repeat (6) @(negedge clk);
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL rst_mid_pipe got %0d returns want 0", got_q.size()); end
    got_q.delete(); got_cyc_q.delete();
  endtask

  initial begin
    test_reset;
    test_basic;
    test_waits;
    test_byteen;
    test_back_to_back;
    test_pipeline;
    test_random;
    test_error;
    test_unselected;
    test_reset_midwait;
    tests++; if (stray_rdv) begin fails++; $display("FAIL rdvalid_tied got 1 want 0 on latency-0 instances"); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
